// File: rtl/data_arbiter_if.sv
// Bus bundle between two requesting masters, the arbiter and a req/gnt/rvalid slave.
// The arbiter takes the slave modport; the environment driving masters and slave takes master.
interface data_arbiter_if;
  logic [1:0]       m_req_i;
  logic [1:0][31:0] m_addr_i;
  logic [1:0]       m_we_i;
  logic [1:0][3:0]  m_be_i;
  logic [1:0][31:0] m_wdata_i;
  logic [1:0]       m_gnt_o;
  logic [1:0]       m_rvalid_o;
  logic [1:0][31:0] m_rdata_o;
  logic             s_req_o;
  logic [31:0]      s_addr_o;
  logic             s_we_o;
  logic [3:0]       s_be_o;
  logic [31:0]      s_wdata_o;
  logic             s_gnt_i;
  logic             s_rvalid_i;
  logic [31:0]      s_rdata_i;
  logic             err_o;
  logic             busy_o;

  modport slave (
    input  m_req_i, m_addr_i, m_we_i, m_be_i, m_wdata_i,
    input  s_gnt_i, s_rvalid_i, s_rdata_i,
    output m_gnt_o, m_rvalid_o, m_rdata_o,
    output s_req_o, s_addr_o, s_we_o, s_be_o, s_wdata_o,
    output err_o, busy_o
  );

  modport master (
    output m_req_i, m_addr_i, m_we_i, m_be_i, m_wdata_i,
    output s_gnt_i, s_rvalid_i, s_rdata_i,
    input  m_gnt_o, m_rvalid_o, m_rdata_o,
    input  s_req_o, s_addr_o, s_we_o, s_be_o, s_wdata_o,
    input  err_o, busy_o
  );
endinterface

// File: rtl/data_arbiter.sv
// Two-master round-robin arbiter for a req/gnt/rvalid slave port, with stall lock
// and an in-order ID FIFO that routes each response back to its issuing master.
module data_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input logic           clk,
  input logic           rst_ni,
  data_arbiter_if.slave bus
);

  generate
    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 8) begin : g_bad_depth
      $error("data_arbiter: MAX_OUTSTANDING must be in 1..8");
    end
  endgenerate

  localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

  logic                       prio_q, prio_d;
  logic                       lock_q, lock_d;
  logic                       lock_id_q, lock_id_d;
  logic [MAX_OUTSTANDING-1:0] fifo_q, fifo_d;
  logic [PW-1:0]              wptr_q, wptr_d;
  logic [PW-1:0]              rptr_q, rptr_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic                       err_q, err_d;

  logic                       sel;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic                       s_req;
  logic                       accept;
  logic                       pop;
  logic                       head;
  logic [1:0]                 m_gnt;
  logic [1:0]                 m_rvalid;
  logic [1:0][31:0]           m_rdata;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    sel = prio_q;
    if (lock_q) begin
      sel = lock_id_q;
    end else if (bus.m_req_i == 2'b01) begin
      sel = 1'b0;
    end else if (bus.m_req_i == 2'b10) begin
      sel = 1'b1;
    end

    fifo_full  = (cnt_q == CW'(MAX_OUTSTANDING));
    fifo_empty = (cnt_q == '0);
    // A full FIFO blocks the request outright, even when a pop frees a slot this cycle.
    s_req      = bus.m_req_i[sel] & ~fifo_full;
    accept     = s_req & bus.s_gnt_i;
    pop        = bus.s_rvalid_i & ~fifo_empty;
    head       = fifo_q[rptr_q];

    m_gnt      = '0;
    m_gnt[sel] = accept;

    m_rvalid = '0;
    m_rdata  = '0;
    if (pop) begin
      m_rvalid[head] = 1'b1;
      m_rdata[head]  = bus.s_rdata_i;
    end

    prio_d    = prio_q;
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    fifo_d    = fifo_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    cnt_d     = cnt_q;
    err_d     = err_q | (bus.s_rvalid_i & fifo_empty);

    if (accept) begin
      fifo_d[wptr_q] = sel;
      wptr_d         = ptr_inc(wptr_q);
      prio_d         = ~sel;
      lock_d         = 1'b0;
    end else if (s_req) begin
      lock_d    = 1'b1;
      lock_id_d = sel;
    end

    if (pop) begin
      rptr_d = ptr_inc(rptr_q);
    end

    case ({accept, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_q    <= 1'b0;
      lock_q    <= 1'b0;
      lock_id_q <= 1'b0;
      fifo_q    <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      prio_q    <= prio_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      fifo_q    <= fifo_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  assign bus.s_req_o    = s_req;
  assign bus.s_addr_o   = s_req ? bus.m_addr_i[sel]  : '0;
  assign bus.s_we_o     = s_req ? bus.m_we_i[sel]    : 1'b0;
  assign bus.s_be_o     = s_req ? bus.m_be_i[sel]    : '0;
  assign bus.s_wdata_o  = s_req ? bus.m_wdata_i[sel] : '0;
  assign bus.m_gnt_o    = m_gnt;
  assign bus.m_rvalid_o = m_rvalid;
  assign bus.m_rdata_o  = m_rdata;
  assign bus.err_o      = err_q;
  assign bus.busy_o     = ~fifo_empty;

endmodule

// File: tb/tb_data_arbiter.sv
// Directed bench for data_arbiter: single read, contention, stall lock, FIFO full,
// spurious response and asynchronous reset, with hand-computed expectations.
module tb_data_arbiter;

  logic clk;
  logic rst_ni;
  int   tests;
  int   failed;

  data_arbiter_if bus ();

  data_arbiter #(.MAX_OUTSTANDING(2)) dut (
    .clk    (clk),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks run near the falling edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.m_req_i    = '0;
    bus.m_addr_i   = '0;
    bus.m_we_i     = '0;
    bus.m_be_i     = '0;
    bus.m_wdata_i  = '0;
    bus.s_gnt_i    = 1'b0;
    bus.s_rvalid_i = 1'b0;
    bus.s_rdata_i  = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_ni = 1'b0;
    #2;
    rst_ni = 1'b1;
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    idle_inputs();
    rst_ni = 1'b0;
    #3;
    chk("rst_gnt",    32'(bus.m_gnt_o),    32'h0);
    chk("rst_rvalid", 32'(bus.m_rvalid_o), 32'h0);
    chk("rst_sreq",   32'(bus.s_req_o),    32'h0);
    chk("rst_saddr",  bus.s_addr_o,        32'h0);
    chk("rst_err",    32'(bus.err_o),      32'h0);
    chk("rst_busy",   32'(bus.busy_o),     32'h0);
    #4;
    rst_ni = 1'b1;

    // Single master read
    cyc();
    bus.m_req_i     = 2'b01;
    bus.m_addr_i[0] = 32'h100;
    bus.m_be_i[0]   = 4'hF;
    bus.s_gnt_i     = 1'b1;
    #3;
    chk("single_sreq",  32'(bus.s_req_o), 32'h1);
    chk("single_saddr", bus.s_addr_o,     32'h100);
    chk("single_sbe",   32'(bus.s_be_o),  32'hF);
    chk("single_gnt",   32'(bus.m_gnt_o), 32'h1);
    cyc();
    bus.m_req_i    = 2'b00;
    bus.s_rvalid_i = 1'b1;
    bus.s_rdata_i  = 32'hDEADBEEF;
    #3;
    chk("single_rvalid", 32'(bus.m_rvalid_o), 32'h1);
    chk("single_rdata0", bus.m_rdata_o[0],    32'hDEADBEEF);
    chk("single_rdata1", bus.m_rdata_o[1],    32'h0);
    chk("single_busy",   32'(bus.busy_o),     32'h1);
    chk("single_saddr0", bus.s_addr_o,        32'h0);
    cyc();
    bus.s_rvalid_i = 1'b0;
    #3;
    chk("single_idle", 32'(bus.busy_o), 32'h0);

    // Contention: both request for 6 cycles, slave answers one cycle after each grant
    cyc();
    do_reset();
    for (int k = 0; k < 6; k++) begin
      cyc();
      bus.m_req_i     = 2'b11;
      bus.m_addr_i[0] = 32'h1000;
      bus.m_addr_i[1] = 32'h2000;
      bus.m_we_i      = 2'b10;
      bus.m_wdata_i[1] = 32'h5555AAAA;
      bus.s_gnt_i     = 1'b1;
      bus.s_rvalid_i  = (k > 0);
      bus.s_rdata_i   = 32'hA0000000 + 32'(k) - 32'h1;
      #3;
      chk("cont_gnt",   32'(bus.m_gnt_o), (k % 2 == 0) ? 32'h1 : 32'h2);
      chk("cont_saddr", bus.s_addr_o,     (k % 2 == 0) ? 32'h1000 : 32'h2000);
      chk("cont_swe",   32'(bus.s_we_o),  (k % 2 == 0) ? 32'h0 : 32'h1);
      if (k > 0) begin
        chk("cont_rvalid", 32'(bus.m_rvalid_o), ((k - 1) % 2 == 0) ? 32'h1 : 32'h2);
        chk("cont_rdata",  bus.m_rdata_o[(k - 1) % 2], 32'hA0000000 + 32'(k) - 32'h1);
      end
    end
    cyc();
    bus.m_req_i    = 2'b00;
    bus.s_rvalid_i = 1'b1;
    bus.s_rdata_i  = 32'hA0000005;
    #3;
    chk("cont_last_rvalid", 32'(bus.m_rvalid_o), 32'h2);
    chk("cont_last_rdata",  bus.m_rdata_o[1],    32'hA0000005);
    cyc();
    bus.s_rvalid_i = 1'b0;
    #3;
    chk("cont_idle", 32'(bus.busy_o), 32'h0);

    // Slave stall with lock: m1 stalled, m0 joins while prio favours m0
    cyc();
    bus.m_req_i     = 2'b10;
    bus.m_addr_i[0] = 32'h200;
    bus.m_addr_i[1] = 32'h300;
    bus.m_we_i      = 2'b00;
    bus.s_gnt_i     = 1'b0;
    #3;
    chk("stall1_saddr", bus.s_addr_o,     32'h300);
    chk("stall1_gnt",   32'(bus.m_gnt_o), 32'h0);
    for (int k = 0; k < 2; k++) begin
      cyc();
      bus.m_req_i = 2'b11;
      #3;
      chk("stall_saddr", bus.s_addr_o,     32'h300);
      chk("stall_gnt",   32'(bus.m_gnt_o), 32'h0);
    end
    cyc();
    bus.s_gnt_i = 1'b1;
    #3;
    chk("stall_rel_saddr", bus.s_addr_o,     32'h300);
    chk("stall_rel_gnt",   32'(bus.m_gnt_o), 32'h2);
    cyc();
    bus.m_req_i = 2'b01;
    #3;
    chk("stall_m0_saddr", bus.s_addr_o,     32'h200);
    chk("stall_m0_gnt",   32'(bus.m_gnt_o), 32'h1);
    cyc();
    bus.m_req_i    = 2'b00;
    bus.s_rvalid_i = 1'b1;
    bus.s_rdata_i  = 32'h11;
    #3;
    chk("stall_resp1", 32'(bus.m_rvalid_o), 32'h2);
    chk("stall_data1", bus.m_rdata_o[1],    32'h11);
    cyc();
    bus.s_rdata_i = 32'h22;
    #3;
    chk("stall_resp0", 32'(bus.m_rvalid_o), 32'h1);
    chk("stall_data0", bus.m_rdata_o[0],    32'h22);
    cyc();
    bus.s_rvalid_i = 1'b0;
    #3;
    chk("stall_idle", 32'(bus.busy_o), 32'h0);

    // FIFO full with responses withheld
    cyc();
    do_reset();
    cyc();
    bus.m_req_i     = 2'b11;
    bus.m_addr_i[0] = 32'h400;
    bus.m_addr_i[1] = 32'h500;
    bus.s_gnt_i     = 1'b1;
    #3;
    chk("full_gnt1", 32'(bus.m_gnt_o), 32'h1);
    cyc();
    #3;
    chk("full_gnt2", 32'(bus.m_gnt_o), 32'h2);
    cyc();
    #3;
    chk("full_sreq",  32'(bus.s_req_o), 32'h0);
    chk("full_gnt",   32'(bus.m_gnt_o), 32'h0);
    chk("full_saddr", bus.s_addr_o,     32'h0);
    chk("full_busy",  32'(bus.busy_o),  32'h1);
    cyc();
    bus.s_rvalid_i = 1'b1;
    bus.s_rdata_i  = 32'h33;
    #3;
    chk("full_nobypass", 32'(bus.s_req_o),    32'h0);
    chk("full_rvalid",   32'(bus.m_rvalid_o), 32'h1);
    cyc();
    bus.s_rvalid_i = 1'b0;
    #3;
    chk("full_resume_sreq", 32'(bus.s_req_o), 32'h1);
    chk("full_resume_gnt",  32'(bus.m_gnt_o), 32'h1);
    cyc();
    #3;
    chk("full_again", 32'(bus.s_req_o), 32'h0);

    // Spurious response on an empty FIFO
    cyc();
    do_reset();
    cyc();
    bus.s_rvalid_i = 1'b1;
    bus.s_rdata_i  = 32'h55;
    #3;
    chk("spur_rvalid", 32'(bus.m_rvalid_o), 32'h0);
    chk("spur_rdata0", bus.m_rdata_o[0],    32'h0);
    chk("spur_err0",   32'(bus.err_o),      32'h0);
    cyc();
    bus.s_rvalid_i = 1'b0;
    #3;
    chk("spur_err1", 32'(bus.err_o), 32'h1);
    cyc();
    #3;
    chk("spur_err_held", 32'(bus.err_o), 32'h1);

    // Reset mid-operation with a transaction outstanding and m1 locked
    cyc();
    bus.m_req_i     = 2'b01;
    bus.m_addr_i[0] = 32'h600;
    bus.m_addr_i[1] = 32'h700;
    bus.s_gnt_i     = 1'b1;
    #3;
    chk("rm_gnt0", 32'(bus.m_gnt_o), 32'h1);
    cyc();
    bus.m_req_i = 2'b10;
    bus.s_gnt_i = 1'b0;
    #3;
    chk("rm_stall_gnt", 32'(bus.m_gnt_o), 32'h0);
    cyc();
    bus.m_req_i = 2'b11;
    #1;
    chk("rm_busy_pre", 32'(bus.busy_o), 32'h1);
    chk("rm_err_pre",  32'(bus.err_o),  32'h1);
    rst_ni = 1'b0;
    #1;
    chk("rm_busy", 32'(bus.busy_o),  32'h0);
    chk("rm_err",  32'(bus.err_o),   32'h0);
    chk("rm_gnt",  32'(bus.m_gnt_o), 32'h0);
    #1;
    rst_ni = 1'b1;
    cyc();
    bus.s_gnt_i = 1'b1;
    #3;
    chk("rm_first_gnt", 32'(bus.m_gnt_o), 32'h1);
    chk("rm_first_addr", bus.s_addr_o,    32'h600);
    cyc();
    #3;
    chk("rm_second_gnt", 32'(bus.m_gnt_o), 32'h2);

    cyc();
    idle_inputs();
    cyc();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
